// File: rtl/wrr_pkg.sv
// rtl/wrr_pkg.sv - shared constants and types for the weighted round-robin scheduler
// Purpose: channel count, weight width, FSM state encoding and reset weights.
// Ports: none (package).
package wrr_pkg;

  localparam int NUM_CH   = 4;
  localparam int WEIGHT_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Channel 0 in the low field: weights 4,3,2,1 for channels 0..3.
  localparam logic [NUM_CH*WEIGHT_W-1:0] RST_WEIGHTS = {3'd1, 3'd2, 3'd3, 3'd4};

endpackage

// File: rtl/wrr_sched_if.sv
// rtl/wrr_sched_if.sv - FIFO-side bundle between the scheduler and its source/destination FIFOs
// Purpose: groups per-channel FIFO status and pop/push strobes.
// Ports (signals): emptyFIFO, almost_fullFIFO (FIFO status), pop, push (scheduler strobes).
//   master: scheduler side; slave: FIFO side.
interface wrr_sched_if #(
  parameter int NUM_CH = 4
);

  logic [NUM_CH-1:0] emptyFIFO;
  logic [NUM_CH-1:0] almost_fullFIFO;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] push;

  modport master (
    input  emptyFIFO,
    input  almost_fullFIFO,
    output pop,
    output push
  );

  modport slave (
    output emptyFIFO,
    output almost_fullFIFO,
    input  pop,
    input  push
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating first-eligible search over four channels
// Purpose: finds the first set bit of eligible scanning upward from ptr, wrapping mod 4.
// Ports: eligible[3:0], ptr[1:0] in; found, idx[1:0] out. Purely combinational.
module rr_pick (
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Scan offsets from high to low so the smallest offset from ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/wrr_sched.sv
// rtl/wrr_sched.sv - weighted round-robin scheduler moving data between four FIFO pairs
// Purpose: serves one channel per turn for up to weight[ch] pops, with one idle bubble between turns.
// Ports: clk, reset (sync, active-high); fifo (wrr_sched_if.master: emptyFIFO, almost_fullFIFO, pop, push);
//   cfg_weights/cfg_load (shadow weight update); grant_id (channel served); turn_done (turn-end pulse).
module wrr_sched #(
  parameter int NUM_CH   = wrr_pkg::NUM_CH,
  parameter int WEIGHT_W = wrr_pkg::WEIGHT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  wrr_sched_if.master                  fifo,
  input  logic [NUM_CH*WEIGHT_W-1:0]   cfg_weights,
  input  logic                         cfg_load,
  output logic [1:0]                   grant_id,
  output logic                         turn_done
);

  import wrr_pkg::*;

  state_t                       state;
  logic [1:0]                   ptr;
  logic [1:0]                   cur;
  logic [WEIGHT_W-1:0]          count;
  logic [NUM_CH*WEIGHT_W-1:0]   shadow_w;
  logic [NUM_CH*WEIGHT_W-1:0]   active_w;

  logic [NUM_CH*WEIGHT_W-1:0]   weight_eff;
  logic [NUM_CH-1:0]            eligible;
  logic [WEIGHT_W-1:0]          cur_weight;
  logic                         serving;
  logic                         last_pop;
  logic                         turn_end;
  logic                         pick_found;
  logic [1:0]                   pick_idx;
  logic [NUM_CH-1:0]            pop_vec;

  // In IDLE the active weights are being reloaded from the shadow at this edge,
  // so the pick must judge eligibility on the weights the new turn will use.
  assign weight_eff = (state == IDLE) ? shadow_w : active_w;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = !fifo.emptyFIFO[i] && !fifo.almost_fullFIFO[i] &&
                    (weight_eff[i*WEIGHT_W +: WEIGHT_W] != '0);
    end
  end

  assign cur_weight = active_w[cur*WEIGHT_W +: WEIGHT_W];
  assign serving    = (state == SERVE) && eligible[cur] && !reset;
  // count < weight always holds in SERVE, so count+1 cannot wrap.
  assign last_pop   = serving && ((count + WEIGHT_W'(1)) == cur_weight);
  assign turn_end   = (state == SERVE) && !reset && (!eligible[cur] || last_pop);

  always_comb begin
    pop_vec = '0;
    if (serving) pop_vec[cur] = 1'b1;
  end

  assign fifo.pop  = pop_vec;
  assign fifo.push = pop_vec;
  assign turn_done = turn_end;
  assign grant_id  = reset ? 2'd0 : cur;

  rr_pick u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      cur      <= 2'd0;
      count    <= '0;
      shadow_w <= RST_WEIGHTS;
      active_w <= RST_WEIGHTS;
    end else begin
      if (cfg_load) shadow_w <= cfg_weights;
      case (state)
        IDLE: begin
          active_w <= shadow_w;
          if (pick_found) begin
            cur   <= pick_idx;
            count <= '0;
            state <= SERVE;
          end
        end
        SERVE: begin
          if (turn_end) begin
            ptr   <= cur + 2'd1;
            count <= '0;
            state <= IDLE;
          end else if (serving) begin
            count <= count + WEIGHT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_sched.sv
// tb/tb_wrr_sched.sv - self-checking bench for the weighted round-robin scheduler
module tb_wrr_sched;

  typedef struct {
    logic [3:0] pop;
    logic       done;
    logic [1:0] gid;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [11:0] cfg_weights;
  logic        cfg_load;
  logic [1:0]  grant_id;
  logic        turn_done;

  int   total;
  int   bad;
  exp_t sb[$];

  wrr_sched_if #(.NUM_CH(4)) fif ();

  wrr_sched dut (
    .clk         (clk),
    .reset       (reset),
    .fifo        (fif),
    .cfg_weights (cfg_weights),
    .cfg_load    (cfg_load),
    .grant_id    (grant_id),
    .turn_done   (turn_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Monitor: structural checks every cycle, scoreboard compare when an entry is pending.
  always @(negedge clk) begin
    exp_t e;
    check("push_eq_pop", 32'(fif.push), 32'(fif.pop));
    check("pop_onehot0", 32'($onehot0(fif.pop)), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pop", 32'(fif.pop), 32'(e.pop));
      check("turn_done", 32'(turn_done), 32'(e.done));
      check("grant_id", 32'(grant_id), 32'(e.gid));
    end
  end

  task automatic cyc(input logic [3:0] p, input logic d, input logic [1:0] g);
    exp_t e;
    e.pop  = p;
    e.done = d;
    e.gid  = g;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic turn(input int ch, input int n);
    for (int i = 0; i < n; i++) cyc(4'(1 << ch), (i == n - 1), 2'(ch));
  endtask

  task automatic bubble(input int ch);
    cyc(4'b0000, 1'b0, 2'(ch));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(4'b0000, 1'b0, 2'd0);
    cyc(4'b0000, 1'b0, 2'd0);
    reset = 1'b0;
  endtask

  initial begin
    total               = 0;
    bad                 = 0;
    reset               = 1'b1;
    cfg_weights         = '0;
    cfg_load            = 1'b0;
    fif.emptyFIFO       = 4'b0000;
    fif.almost_fullFIFO = 4'b0000;
    @(posedge clk);
    #1;

    // Nominal rotation with reset weights 4,3,2,1.
    do_reset();
    bubble(0);
    turn(0, 4); bubble(0);
    turn(1, 3); bubble(1);
    turn(2, 2); bubble(2);
    turn(3, 1); bubble(3);
    turn(0, 4); bubble(0);

    // Channel 1 empty: skipped without an extra bubble.
    fif.emptyFIFO = 4'b0010;
    do_reset();
    bubble(0);
    turn(0, 4); bubble(0);
    turn(2, 2); bubble(2);
    turn(3, 1); bubble(3);
    turn(0, 4); bubble(0);
    fif.emptyFIFO = 4'b0000;

    // Destination 0 almost full after two pops ends the turn at once.
    do_reset();
    bubble(0);
    cyc(4'b0001, 1'b0, 2'd0);
    cyc(4'b0001, 1'b0, 2'd0);
    fif.almost_fullFIFO = 4'b0001;
    cyc(4'b0000, 1'b1, 2'd0);
    bubble(0);
    turn(1, 3); bubble(1);
    turn(2, 2); bubble(2);
    turn(3, 1); bubble(3);
    turn(1, 3); bubble(1);
    fif.almost_fullFIFO = 4'b0000;

    // Weight reload mid-turn: ch0 keeps its old weight, then all weights are 1.
    do_reset();
    bubble(0);
    cyc(4'b0001, 1'b0, 2'd0);
    cfg_weights = 12'o1111;
    cfg_load    = 1'b1;
    cyc(4'b0001, 1'b0, 2'd0);
    cfg_load    = 1'b0;
    cyc(4'b0001, 1'b0, 2'd0);
    cyc(4'b0001, 1'b1, 2'd0);
    bubble(0);
    turn(1, 1); bubble(1);
    turn(2, 1); bubble(2);
    turn(3, 1); bubble(3);
    turn(0, 1); bubble(0);

    // Reset after the second ch1 pop aborts the turn; service restarts at ch0.
    do_reset();
    bubble(0);
    turn(0, 4); bubble(0);
    cyc(4'b0010, 1'b0, 2'd1);
    cyc(4'b0010, 1'b0, 2'd1);
    reset = 1'b1;
    cyc(4'b0000, 1'b0, 2'd0);
    reset = 1'b0;
    bubble(0);
    turn(0, 4); bubble(0);

    // Load all-zero weights in the first IDLE cycle: previous shadow still
    // applies to this pick, then the scheduler idles forever.
    do_reset();
    cfg_weights = 12'o0000;
    cfg_load    = 1'b1;
    bubble(0);
    cfg_load    = 1'b0;
    turn(0, 4);
    for (int i = 0; i < 8; i++) bubble(0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wrr_sched.md
WRR_SCHED -- requirements
Module: wrr_sched

Interface
REQ-001 The block SHALL use parameter NUM_CH, default 4, meaning number of FIFO channels; only 4 is supported.
REQ-002 The block SHALL use parameter WEIGHT_W, default 3, meaning width of each per-channel weight.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port emptyFIFO, input, 4 bits: bit i high means source FIFO i is empty.
REQ-006 The block SHALL have port almost_fullFIFO, input, 4 bits: bit i high means destination FIFO i is almost full.
REQ-007 The block SHALL have port cfg_weights, input, 12 bits: bits [3i+2:3i] are the requested weight of channel i.
REQ-008 The block SHALL have port cfg_load, input, 1 bit: one-cycle strobe that captures cfg_weights into the shadow register.
REQ-009 The block SHALL have port pop, output, 4 bits: pops source FIFO i; at most one bit high per cycle.
REQ-010 The block SHALL have port push, output, 4 bits: pushes destination FIFO i; always equal to pop.
REQ-011 The block SHALL have port grant_id, output, 2 bits: index of the channel currently being served.
REQ-012 The block SHALL have port turn_done, output, 1 bit: one-cycle pulse in the cycle a service turn ends.

Function
REQ-013 Eligible(i) SHALL be defined as !emptyFIFO[i] && !almost_fullFIFO[i] && active weight[i] != 0.
REQ-014 The FSM SHALL have exactly two states, IDLE and SERVE.
REQ-015 In IDLE, pop SHALL be 0, and the active weights SHALL be loaded from the shadow register.
REQ-016 In IDLE, if any channel is eligible, the block SHALL pick the first eligible channel scanning upward from ptr (mod 4), set cur to it, clear count, and enter SERVE next cycle; otherwise it SHALL stay in IDLE.
REQ-017 In SERVE, pop[cur] and push[cur] SHALL be high combinationally when Eligible(cur); all other bits SHALL be 0.
REQ-018 Each cycle with pop[cur] high SHALL increment count, which is WEIGHT_W bits wide and cannot overflow because it is bounded by the weight.
REQ-019 A turn SHALL end in the cycle where pop[cur] is high and count+1 == weight[cur], or in any SERVE cycle where Eligible(cur) is false (skip, zero pop).
REQ-020 On turn end, turn_done SHALL pulse, ptr SHALL become (cur+1) mod 4 with 3 wrapping to 0, and the state SHALL return to IDLE; this costs one mandatory bubble cycle between turns.
REQ-021 grant_id SHALL equal cur in SERVE and hold its last value in IDLE.
REQ-022 cfg_load SHALL be accepted in any state; the new weights SHALL take effect only at the next IDLE cycle, and a turn in progress SHALL complete with its old weight.
REQ-023 If cfg_load and an IDLE cycle coincide, the active weights SHALL take the previous shadow value, and the new shadow value SHALL apply from the following IDLE cycle.
REQ-024 When all weights are 0, the block SHALL remain in IDLE with pop = 0 indefinitely.
REQ-025 When almost_fullFIFO[cur] rises mid-turn, the block SHALL de-assert pop[cur] in that same cycle and end the turn.

Reset
REQ-026 While reset = 1 at a clock edge, the block SHALL set state to IDLE, ptr to 0, cur to 0, and count to 0.
REQ-027 Reset SHALL set the shadow and active weights to 4,3,2,1 for channels 0..3.
REQ-028 Reset SHALL force pop, push and turn_done to 0 and grant_id to 0 in the cycle reset is high.
REQ-029 Reset asserted mid-turn SHALL abort the turn with no further pops and no turn_done pulse.

Structure
REQ-030 A shared package wrr_pkg SHALL hold NUM_CH, WEIGHT_W, the state enumeration {IDLE, SERVE} and the reset weight constants.
REQ-031 A sub-module rr_pick SHALL implement the rotating first-eligible search: inputs eligible[3:0] and ptr[1:0]; outputs found and idx[1:0]; purely combinational.

Verification
REQ-032 After reset with all FIFOs non-empty and not almost full, the bench SHALL see the pop sequence ch0 x4, bubble, ch1 x3, bubble, ch2 x2, bubble, ch3 x1, bubble, then a repeat starting at ch0.
REQ-033 With emptyFIFO = 4'b0010 and other conditions nominal, channel 1 SHALL never pop, and ch0 x4 SHALL be followed by ch2 x2 after a single bubble.
REQ-034 Raising almost_fullFIFO[0] after 2 pops of ch0 SHALL drop pop[0] in that cycle, pulse turn_done, and make ch1 the next served channel.
REQ-035 Pulsing cfg_load with weights 1,1,1,1 during a ch0 turn SHALL let ch0 finish 4 pops, then each channel SHALL pop once per turn.
REQ-036 Asserting reset during the 2nd pop of ch1 SHALL make pop = 0 the next cycle, after which service SHALL restart at ch0 with weight 4.
REQ-037 Across all scenarios, the bench SHALL check every cycle that push == pop and that pop is one-hot or zero.
